// File: rtl/logip_pkg.sv
// Shared types for the logic-analyzer capture controller: FSM state type and
// the encodings exposed on the optional status port.
package logip_pkg;

  localparam logic [2:0] ENC_IDLE    = 3'd0;
  localparam logic [2:0] ENC_ARMED   = 3'd1;
  localparam logic [2:0] ENC_POST    = 3'd2;
  localparam logic [2:0] ENC_RD_REQ  = 3'd3;
  localparam logic [2:0] ENC_RD_WAIT = 3'd4;
  localparam logic [2:0] ENC_RD_SEND = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ENC_IDLE,
    ARMED   = ENC_ARMED,
    POST    = ENC_POST,
    RD_REQ  = ENC_RD_REQ,
    RD_WAIT = ENC_RD_WAIT,
    RD_SEND = ENC_RD_SEND
  } ctrl_state_e;

endpackage

// File: rtl/capture_ctrl.sv
// Capture/readback sequencer: writes cache words into a circular sample memory,
// stops after a post-trigger delay, then reads words back newest-first.
// Optional status port (state_o, wrapped_o) is built when LOGIP_CTRL_STATUS_EN is defined.
//
// state   | meaning
// IDLE    | waiting for cfg strobe / arm
// ARMED   | capturing, waiting for first trigger
// POST    | capturing, counting post-trigger words
// RD_REQ  | memory read strobe at rd_ptr
// RD_WAIT | registering memory read data
// RD_SEND | presenting word to transmitter until ack
module capture_ctrl
  import logip_pkg::*;
#(
  parameter int OUTPUT = 4,
  parameter int DEPTH  = 4096,
  parameter int CNT_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_in,
  input  logic                       cmd_arm_i,
  input  logic                       cmd_reset_i,
  input  logic                       cfg_stb_i,
  input  logic [CNT_W-1:0]           cfg_delay_i,
  input  logic [CNT_W-1:0]           cfg_read_i,
  input  logic                       trg_i,
  input  logic                       cache_stb_i,
  input  logic [OUTPUT*8-1:0]        cache_q_i,
  output logic                       cache_en_o,
  output logic                       mem_we_o,
  output logic                       mem_re_o,
  output logic [$clog2(DEPTH)-1:0]   mem_addr_o,
  output logic [OUTPUT*8-1:0]        mem_d_o,
  input  logic [OUTPUT*8-1:0]        mem_q_i,
  output logic                       tx_stb_o,
  output logic [OUTPUT*8-1:0]        tx_q_o,
`ifdef LOGIP_CTRL_STATUS_EN
  output logic [2:0]                 state_o,
  output logic                       wrapped_o,
`endif
  input  logic                       tx_ack_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = OUTPUT * 8;

  ctrl_state_e      r_state, w_state_nxt;
  logic [AW-1:0]    r_wr_ptr, w_wr_ptr_nxt;
  logic [AW-1:0]    r_rd_ptr, w_rd_ptr_nxt;
  logic [CNT_W-1:0] r_delay, r_read;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_rem, w_rem_nxt;
  logic [DW-1:0]    r_tx_q, w_tx_q_nxt;
  logic             w_capture, w_post_done, w_we, w_re, w_cfg_ld, w_arm;

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_cnt_nxt    = r_cnt;
    w_rem_nxt    = r_rem;
    w_tx_q_nxt   = r_tx_q;
    w_cfg_ld     = 1'b0;
    w_arm        = 1'b0;

    w_capture   = (r_state == ARMED) || (r_state == POST);
    // Once the post-trigger count is exhausted no further word belongs to this capture.
    w_post_done = (r_state == POST) && (r_cnt == '0);
    w_we        = w_capture && cache_stb_i && !w_post_done && !cmd_reset_i;
    w_re        = (r_state == RD_REQ) && !cmd_reset_i;

    if (w_we) w_wr_ptr_nxt = r_wr_ptr + AW'(1);

    case (r_state)
      IDLE: begin
        w_cfg_ld = cfg_stb_i;
        if (cmd_arm_i) begin
          w_arm       = 1'b1;
          w_state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (trg_i) begin
          w_state_nxt = POST;
          w_cnt_nxt   = r_delay;
        end
      end
      POST: begin
        if (w_post_done || (w_we && (r_cnt == CNT_W'(1)))) begin
          w_cnt_nxt    = '0;
          w_rd_ptr_nxt = w_wr_ptr_nxt - AW'(1);
          w_rem_nxt    = r_read;
          w_state_nxt  = (r_read == '0) ? IDLE : RD_REQ;
        end else if (w_we) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      RD_REQ:  w_state_nxt = RD_WAIT;
      RD_WAIT: begin
        w_tx_q_nxt  = mem_q_i;
        w_state_nxt = RD_SEND;
      end
      RD_SEND: begin
        if (tx_ack_i) begin
          w_rd_ptr_nxt = r_rd_ptr - AW'(1);
          w_rem_nxt    = r_rem - CNT_W'(1);
          w_state_nxt  = (r_rem == CNT_W'(1)) ? IDLE : RD_REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Soft abort keeps write pointer and configuration, discards everything else in flight.
    if (cmd_reset_i) begin
      w_state_nxt  = IDLE;
      w_rd_ptr_nxt = r_rd_ptr;
      w_cnt_nxt    = r_cnt;
      w_rem_nxt    = r_rem;
      w_tx_q_nxt   = r_tx_q;
      w_cfg_ld     = 1'b0;
      w_arm        = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_delay  <= '0;
      r_read   <= '0;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_tx_q   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rem    <= w_rem_nxt;
      r_tx_q   <= w_tx_q_nxt;
      if (w_cfg_ld) begin
        r_delay <= cfg_delay_i;
        r_read  <= cfg_read_i;
      end
    end
  end

  assign cache_en_o = w_capture;
  assign mem_we_o   = w_we;
  assign mem_re_o   = w_re;
  assign mem_addr_o = w_we ? r_wr_ptr : (w_re ? r_rd_ptr : '0);
  assign mem_d_o    = w_we ? cache_q_i : '0;
  assign tx_stb_o   = (r_state == RD_SEND) && !cmd_reset_i;
  assign tx_q_o     = r_tx_q;

`ifdef LOGIP_CTRL_STATUS_EN
  logic r_wrapped;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_wrapped <= 1'b0;
    end else if (w_arm) begin
      r_wrapped <= 1'b0;
    end else if (w_we && (r_wr_ptr == '1)) begin
      r_wrapped <= 1'b1;
    end
  end

  assign state_o   = r_state;
  assign wrapped_o = r_wrapped;
`endif

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl (DEPTH=16, OUTPUT=4): capture writes are
// checked as they happen, readback is checked against a queue-based scoreboard.
module tb_capture_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_in = 1'b0;
  logic        cmd_arm_i = 1'b0;
  logic        cmd_reset_i = 1'b0;
  logic        cfg_stb_i = 1'b0;
  logic [15:0] cfg_delay_i = '0;
  logic [15:0] cfg_read_i = '0;
  logic        trg_i = 1'b0;
  logic        cache_stb_i = 1'b0;
  logic [31:0] cache_q_i = '0;
  logic        cache_en_o, mem_we_o, mem_re_o, tx_stb_o;
  logic [3:0]  mem_addr_o;
  logic [31:0] mem_d_o, tx_q_o;
  logic [31:0] mem_q_i = '0;
  logic        tx_ack_i = 1'b0;
`ifdef LOGIP_CTRL_STATUS_EN
  logic [2:0]  state_o;
  logic        wrapped_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem_array [16];
  logic [31:0] m_mem [16];
  logic [3:0]  m_wr_ptr = '0;
  logic [3:0]  exp_addr [$];
  logic [31:0] exp_tx [$];

  capture_ctrl #(.OUTPUT(4), .DEPTH(16), .CNT_W(16)) dut (
    .clk_i       (clk_i),
    .rst_in      (rst_in),
    .cmd_arm_i   (cmd_arm_i),
    .cmd_reset_i (cmd_reset_i),
    .cfg_stb_i   (cfg_stb_i),
    .cfg_delay_i (cfg_delay_i),
    .cfg_read_i  (cfg_read_i),
    .trg_i       (trg_i),
    .cache_stb_i (cache_stb_i),
    .cache_q_i   (cache_q_i),
    .cache_en_o  (cache_en_o),
    .mem_we_o    (mem_we_o),
    .mem_re_o    (mem_re_o),
    .mem_addr_o  (mem_addr_o),
    .mem_d_o     (mem_d_o),
    .mem_q_i     (mem_q_i),
    .tx_stb_o    (tx_stb_o),
    .tx_q_o      (tx_q_o),
`ifdef LOGIP_CTRL_STATUS_EN
    .state_o     (state_o),
    .wrapped_o   (wrapped_o),
`endif
    .tx_ack_i    (tx_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // Sample memory: synchronous write, read data one cycle after the read strobe.
  always @(posedge clk_i) begin
    if (mem_we_o) mem_array[mem_addr_o] <= mem_d_o;
    if (mem_re_o) mem_q_i <= mem_array[mem_addr_o];
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    cmd_arm_i = 0; cmd_reset_i = 0; cfg_stb_i = 0; trg_i = 0;
    cache_stb_i = 0; cache_q_i = '0; tx_ack_i = 0;
    repeat (2) @(posedge clk_i);
    #3 rst_in = 1'b1;
    m_wr_ptr = '0;
    exp_addr.delete();
    exp_tx.delete();
  endtask

  task automatic cfg_arm(input logic do_cfg, input int dly, input int rd);
    step();
    cfg_stb_i = do_cfg; cfg_delay_i = 16'(dly); cfg_read_i = 16'(rd);
    cmd_arm_i = 1'b1; cmd_reset_i = 0; cache_stb_i = 0; trg_i = 0;
    #1;
  endtask

  task automatic idle_cycle();
    step();
    cmd_arm_i = 0; cmd_reset_i = 0; cfg_stb_i = 0; cache_stb_i = 0; trg_i = 0;
    #1;
  endtask

  task automatic put_word(input logic [31:0] d, input logic trg, input logic exp_we, input logic exp_en);
    step();
    cmd_arm_i = 0; cmd_reset_i = 0; cfg_stb_i = 0;
    cache_stb_i = 1'b1; cache_q_i = d; trg_i = trg;
    #1;
    n_checks++;
    if (cache_en_o !== exp_en) begin
      n_errors++;
      $display("FAIL cache_en word %h: got %b want %b", d, cache_en_o, exp_en);
    end
    n_checks++;
    if (mem_we_o !== exp_we || (exp_we && (mem_addr_o !== m_wr_ptr || mem_d_o !== d))) begin
      n_errors++;
      $display("FAIL write word %h: got we=%b addr=%h d=%h want we=%b addr=%h", d, mem_we_o, mem_addr_o, mem_d_o, exp_we, m_wr_ptr);
    end
    if (exp_we) begin
      m_mem[m_wr_ptr] = d;
      m_wr_ptr = m_wr_ptr + 4'd1;
    end
  endtask

  task automatic push_readback(input int n);
    logic [3:0] a;
    for (int i = 0; i < n; i++) begin
      a = m_wr_ptr - 4'(1 + i);
      exp_addr.push_back(a);
      exp_tx.push_back(m_mem[a]);
    end
  endtask

  // Entered 2 time units after an edge, with the current cycle's outputs settled.
  task automatic drain(input int ack_delay, input int budget);
    int cyc = 0;
    int wait_cnt = 0;
    logic [31:0] held = '0;
    logic [3:0]  a;
    logic [31:0] d;
    while ((exp_addr.size() != 0 || exp_tx.size() != 0) && cyc < budget) begin
      tx_ack_i = 1'b0;
      if (mem_re_o) begin
        n_checks++;
        if (mem_we_o !== 1'b0 || exp_addr.size() == 0) begin
          n_errors++;
          $display("FAIL read_strobe: got re=1 we=%b pending=%0d want we=0 pending>0", mem_we_o, exp_addr.size());
        end else begin
          a = exp_addr.pop_front();
          if (mem_addr_o !== a) begin
            n_errors++;
            $display("FAIL read_addr: got %h want %h", mem_addr_o, a);
          end
        end
      end
      if (tx_stb_o) begin
        if (wait_cnt == 0) held = tx_q_o;
        else begin
          n_checks++;
          if (tx_q_o !== held) begin
            n_errors++;
            $display("FAIL tx_hold: got %h want %h", tx_q_o, held);
          end
        end
        if (wait_cnt == ack_delay) begin
          tx_ack_i = 1'b1;
          wait_cnt = 0;
          n_checks++;
          if (exp_tx.size() == 0) begin
            n_errors++;
            $display("FAIL tx_extra: got %h want none", tx_q_o);
          end else begin
            d = exp_tx.pop_front();
            if (tx_q_o !== d) begin
              n_errors++;
              $display("FAIL tx_data: got %h want %h", tx_q_o, d);
            end
          end
        end else begin
          wait_cnt++;
        end
      end
      @(posedge clk_i);
      #2;
      cyc++;
    end
    if (cyc >= budget) begin
      n_checks++;
      n_errors++;
      $display("FAIL readback_timeout: got %0d words left want 0", exp_tx.size());
      exp_addr.delete();
      exp_tx.delete();
    end
    if (tx_ack_i) begin
      @(posedge clk_i);
      #2;
    end
    tx_ack_i = 1'b0;
    repeat (3) begin
      n_checks++;
      if (mem_re_o !== 1'b0 || tx_stb_o !== 1'b0 || cache_en_o !== 1'b0) begin
        n_errors++;
        $display("FAIL readback_tail: got re=%b stb=%b en=%b want 0 0 0", mem_re_o, tx_stb_o, cache_en_o);
      end
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (cache_en_o !== 0 || mem_we_o !== 0 || mem_re_o !== 0 || mem_addr_o !== 0 ||
        mem_d_o !== 0 || tx_stb_o !== 0 || tx_q_o !== 0) begin
      n_errors++;
      $display("FAIL reset_outputs: got en=%b we=%b re=%b addr=%h d=%h stb=%b q=%h want all 0",
               cache_en_o, mem_we_o, mem_re_o, mem_addr_o, mem_d_o, tx_stb_o, tx_q_o);
    end
`ifdef LOGIP_CTRL_STATUS_EN
    n_checks++;
    if (state_o !== 3'd0 || wrapped_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_status: got state=%0d wrapped=%b want 0 0", state_o, wrapped_o);
    end
`endif
  endtask

  task automatic test_reset_mid_send();
    int k = 0;
    do_reset();
    cfg_arm(1'b1, 0, 1);
    put_word(32'h0000_00AA, 1'b1, 1'b1, 1'b1);
    idle_cycle();
    while (!tx_stb_o && k < 8) begin
      idle_cycle();
      k++;
    end
    n_checks++;
    if (tx_stb_o !== 1'b1 || tx_q_o !== 32'h0000_00AA) begin
      n_errors++;
      $display("FAIL pre_reset_send: got stb=%b q=%h want 1 000000aa", tx_stb_o, tx_q_o);
    end
    rst_in = 1'b0;
    #1;
    n_checks++;
    if (cache_en_o !== 0 || mem_we_o !== 0 || mem_re_o !== 0 || mem_addr_o !== 0 ||
        mem_d_o !== 0 || tx_stb_o !== 0 || tx_q_o !== 0) begin
      n_errors++;
      $display("FAIL async_reset: got en=%b re=%b stb=%b q=%h want all 0", cache_en_o, mem_re_o, tx_stb_o, tx_q_o);
    end
    repeat (2) @(posedge clk_i);
    #3 rst_in = 1'b1;
    m_wr_ptr = '0;
    // cfg registers are back to 0, so this capture ends with no readback.
    cfg_arm(1'b0, 0, 0);
    put_word(32'h0000_0055, 1'b1, 1'b1, 1'b1);
    idle_cycle();
    n_checks++;
    if (cache_en_o !== 1'b1 || mem_re_o !== 1'b0) begin
      n_errors++;
      $display("FAIL rearm_post: got en=%b re=%b want 1 0", cache_en_o, mem_re_o);
    end
    idle_cycle();
    n_checks++;
    if (cache_en_o !== 1'b0 || mem_re_o !== 1'b0 || tx_stb_o !== 1'b0) begin
      n_errors++;
      $display("FAIL rearm_read0_idle: got en=%b re=%b stb=%b want 0 0 0", cache_en_o, mem_re_o, tx_stb_o);
    end
  endtask

  task automatic test_basic_capture();
    do_reset();
    cfg_arm(1'b1, 3, 5);
    for (int k = 1; k <= 9; k++)
      put_word(32'(k), 1'(k == 6), 1'b1, 1'b1);
    push_readback(5);
    put_word(32'd10, 1'b0, 1'b0, 1'b0);
    drain(0, 100);
`ifdef LOGIP_CTRL_STATUS_EN
    n_checks++;
    if (wrapped_o !== 1'b0) begin
      n_errors++;
      $display("FAIL wrapped_nowrap: got %b want 0", wrapped_o);
    end
`endif
  endtask

  task automatic test_delay0_edge();
    do_reset();
    cfg_arm(1'b1, 0, 2);
    step();
    cmd_arm_i = 0; cfg_stb_i = 0; cache_stb_i = 0; trg_i = 1'b1;
    #1;
    n_checks++;
    if (cache_en_o !== 1'b1 || mem_we_o !== 1'b0) begin
      n_errors++;
      $display("FAIL d0_trigger: got en=%b we=%b want 1 0", cache_en_o, mem_we_o);
    end
    idle_cycle();
    n_checks++;
    if (cache_en_o !== 1'b1 || mem_re_o !== 1'b0) begin
      n_errors++;
      $display("FAIL d0_post: got en=%b re=%b want 1 0", cache_en_o, mem_re_o);
    end
    push_readback(2);
    idle_cycle();
    n_checks++;
    if (mem_re_o !== 1'b1 || mem_addr_o !== 4'd15) begin
      n_errors++;
      $display("FAIL d0_rd_req: got re=%b addr=%h want 1 f", mem_re_o, mem_addr_o);
    end
    drain(0, 50);
  endtask

  task automatic test_wrap();
    do_reset();
    cfg_arm(1'b1, 0, 16);
    for (int k = 0; k < 20; k++)
      put_word(32'h100 + 32'(k), 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (m_wr_ptr !== 4'd4) begin
      n_errors++;
      $display("FAIL wrap_model_ptr: got %0d want 4", m_wr_ptr);
    end
    step();
    cache_stb_i = 0; trg_i = 1'b1;
    #1;
    idle_cycle();
    push_readback(16);
    idle_cycle();
    drain(0, 200);
`ifdef LOGIP_CTRL_STATUS_EN
    n_checks++;
    if (wrapped_o !== 1'b1) begin
      n_errors++;
      $display("FAIL wrapped_set: got %b want 1", wrapped_o);
    end
`endif
  endtask

  task automatic test_slow_ack();
    do_reset();
    cfg_arm(1'b1, 1, 3);
    put_word(32'hA1, 1'b0, 1'b1, 1'b1);
    put_word(32'hA2, 1'b1, 1'b1, 1'b1);
    put_word(32'hA3, 1'b0, 1'b1, 1'b1);
    push_readback(3);
    idle_cycle();
    drain(5, 100);
  endtask

  task automatic test_abort_and_ignore();
    do_reset();
    cfg_arm(1'b1, 2, 4);
    put_word(32'h61, 1'b0, 1'b1, 1'b1);
    step();
    cache_stb_i = 0; trg_i = 0;
    cfg_stb_i = 1'b1; cfg_delay_i = 16'd7; cfg_read_i = 16'd9; cmd_arm_i = 1'b1;
    #1;
    n_checks++;
    if (cache_en_o !== 1'b1) begin
      n_errors++;
      $display("FAIL armed_en: got %b want 1", cache_en_o);
    end
    put_word(32'h62, 1'b1, 1'b1, 1'b1);
    put_word(32'h63, 1'b0, 1'b1, 1'b1);
    step();
    cmd_reset_i = 1'b1; cache_stb_i = 1'b1; cache_q_i = 32'h64;
    #1;
    n_checks++;
    if (mem_we_o !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_cycle_we: got %b want 0", mem_we_o);
    end
    step();
    cmd_reset_i = 1'b0; cache_stb_i = 1'b1; cache_q_i = 32'h65;
    #1;
    n_checks++;
    if (cache_en_o !== 1'b0 || mem_we_o !== 1'b0 || mem_re_o !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_idle: got en=%b we=%b re=%b want 0 0 0", cache_en_o, mem_we_o, mem_re_o);
    end
    // Original cfg (delay 2, read 4) must still be in force; write pointer continues.
    cfg_arm(1'b0, 0, 0);
    put_word(32'h71, 1'b1, 1'b1, 1'b1);
    put_word(32'h72, 1'b0, 1'b1, 1'b1);
    put_word(32'h73, 1'b0, 1'b1, 1'b1);
    push_readback(4);
    put_word(32'h74, 1'b0, 1'b0, 1'b0);
    drain(1, 100);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_array[i] = '0;
      m_mem[i] = '0;
    end
    test_reset();
    test_reset_mid_send();
    test_basic_capture();
    test_delay0_edge();
    test_wrap();
    test_slow_ack();
    test_abort_and_ignore();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
Sequencer for the byte-packing cache path and the sample memory of the logic analyzer.
- Enables the cache while armed and writes each packed cache word into a circular sample memory.
- Counts post-trigger words and stops capture after the configured delay.
- Reads the stored words back newest-first to the transmit path over a valid/ack handshake.
- Sits between the trigger unit/cache on the capture side and memory/UART-TX on the readback side.

Parameters:
OUTPUT, 4, bytes per memory word; must equal the cache OUTPUT width.
DEPTH, 4096, memory words; power of two, at least 2.
CNT_W, 16, width of the delay and read counters.

Ports:
clk_i  in  1  system clock
rst_in  in  1  reset, asynchronous, active-low
cmd_arm_i  in  1  start capture; honoured only in IDLE
cmd_reset_i  in  1  soft abort; returns to IDLE from any state
cfg_stb_i  in  1  latch cfg_delay_i/cfg_read_i; honoured only in IDLE
cfg_delay_i  in  CNT_W  number of words written after the trigger word
cfg_read_i  in  CNT_W  number of words returned on readback
trg_i  in  1  trigger hit, single-cycle or level
cache_stb_i  in  1  packed word valid from cache
cache_q_i  in  OUTPUT*8  packed word
cache_en_o  out  1  cache/write enable to cache
mem_we_o  out  1  memory write strobe
mem_re_o  out  1  memory read strobe
mem_addr_o  out  $clog2(DEPTH)  memory address
mem_d_o  out  OUTPUT*8  memory write data
mem_q_i  in  OUTPUT*8  memory read data, valid 1 cycle after mem_re_o
tx_stb_o  out  1  readback word valid
tx_q_o  out  OUTPUT*8  readback word
tx_ack_i  in  1  transmitter accepted word

Behaviour:
- Reset values: all outputs 0; state IDLE; wr_ptr 0; delay register 0; read register 0.
- States: IDLE, ARMED, POST, RD_REQ, RD_WAIT, RD_SEND.
- cmd_reset_i has priority over every transition. Next state is IDLE with all strobes low; wr_ptr is kept; latched cfg is kept.
- IDLE:
  - cache_en_o=0.
  - cfg_stb_i latches both cfg values.
  - cmd_arm_i goes to ARMED.
- ARMED and POST (capture):
  - cache_en_o=1.
  - On each cache_stb_i, in the same cycle: mem_we_o=1, mem_addr_o=wr_ptr, mem_d_o=cache_q_i. wr_ptr then increments mod DEPTH; wrap is silent and overwrites the oldest data.
- ARMED to POST:
  - Triggered on the first cycle trg_i=1. Further trg_i pulses are ignored until the next arm.
  - The delay counter loads cfg_delay. A write in the trigger cycle is performed but not counted.
- POST:
  - Each cache_stb_i write decrements the counter.
  - When the counter is 0 (at entry or after a decrement), the next state is RD_REQ. cfg_delay=0 leaves POST one cycle after the trigger.
  - cache_en_o drops on entry to RD_REQ. Cache words arriving after that are dropped.
- Readback:
  - rd_ptr = wr_ptr-1 mod DEPTH (newest first); remaining counter = cfg_read.
  - If cfg_read=0, go directly to IDLE.
- RD_REQ: mem_re_o=1, mem_addr_o=rd_ptr, for one cycle; then RD_WAIT.
- RD_WAIT: register mem_q_i into tx_q_o; then RD_SEND.
- RD_SEND:
  - tx_stb_o=1 and tx_q_o held stable until tx_ack_i.
  - On ack: rd_ptr decrements mod DEPTH and remaining decrements.
  - If remaining reaches 0, go to IDLE; else RD_REQ.
  - Ack in the first RD_SEND cycle is legal.
  - cfg_read > DEPTH is allowed; the read pointer wraps and re-reads older slots.
- Latency: 3 cycles minimum per word with immediate ack.
- mem_we_o and mem_re_o are never both high.

Optional Feature:
LOGIP_CTRL_STATUS_EN
- Defined: adds output state_o [2:0] (encoded state) and output wrapped_o.
  - wrapped_o is set when wr_ptr wraps during capture and cleared on arm.
- Undefined: these ports and the logic behind them are absent; no other behaviour changes.

Decomposition:
- logip_pkg holds the ctrl_state_e typedef (6 states, 3 bits) and the state encoding constants used by the status port.
- Single module. Pointer and counter logic is inline; no sub-module is natural at this size.

Test Plan:
All scenarios use DEPTH=16, OUTPUT=4.
1. Reset mid-RD_SEND (async rst_in pulse) -> all outputs 0 immediately, state IDLE, the next arm works.
2. cfg delay=3, read=5; arm; 10 cache words 0x00000001..0x0000000A; trg_i with word 6 -> writes addr 0..8, cache_en_o falls after word 9, readback emits 9,8,7,6,5 (values), then IDLE.
3. delay=0, read=2, trigger with no word in flight -> RD_REQ one cycle later; readback addr 15,14 when wr_ptr=0.
4. 20 words before trigger, delay=0, read=16 -> wr_ptr=4; readback addr 3..0,15..4; wrapped_o=1 with LOGIP_CTRL_STATUS_EN.
5. tx_ack_i delayed 5 cycles per word -> tx_stb_o/tx_q_o held stable; no extra mem_re_o.
6. cmd_reset_i in POST, and arm/cfg_stb_i while ARMED -> reset returns to IDLE with cache_en_o=0; arm/cfg are ignored and cfg is unchanged.
